// File: rtl/riscv_mem_arbiter.sv
// Round-robin 2:1 memory request arbiter with an in-order tag FIFO routing responses back to the issuing port.
// Define RISCV_MEM_ARB_STATS_EN to add hierarchically readable grant/conflict/stall counters.
module riscv_mem_arbiter #(
    parameter int p_req_sz  = 67,
    parameter int p_resp_sz = 35,
    parameter int p_max_out = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [p_req_sz-1:0]  req0_msg,
    input  logic                 req0_val,
    output logic                 req0_rdy,

    input  logic [p_req_sz-1:0]  req1_msg,
    input  logic                 req1_val,
    output logic                 req1_rdy,

    output logic [p_resp_sz-1:0] resp0_msg,
    output logic                 resp0_val,

    output logic [p_resp_sz-1:0] resp1_msg,
    output logic                 resp1_val,

    output logic [p_req_sz-1:0]  memreq_msg,
    output logic                 memreq_val,
    input  logic                 memreq_rdy,

    input  logic [p_resp_sz-1:0] memresp_msg,
    input  logic                 memresp_val,

    output logic                 err
);

    localparam int c_ptr_w = (p_max_out > 1) ? $clog2(p_max_out) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(p_max_out);

    logic                 last_grant;
    logic [p_max_out-1:0] tag_q;
    logic [c_ptr_w-1:0]   head_ptr;
    logic [c_ptr_w-1:0]   tail_ptr;
    logic [c_cnt_w-1:0]   count;
    logic                 err_q;

    logic any_val;
    logic both_val;
    logic grant;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_tag;

    // Only one valid port wins outright; on conflict the port not granted last time wins.
    // With no valid port grant falls to 0, which also selects port 0's message.
    assign any_val  = req0_val | req1_val;
    assign both_val = req0_val & req1_val;
    assign grant    = both_val ? ~last_grant : req1_val;

    assign full  = (count == c_max_cnt);
    assign empty = (count == '0);

    assign memreq_val = any_val & ~full;
    assign memreq_msg = grant ? req1_msg : req0_msg;

    assign req0_rdy = any_val & ~grant & memreq_rdy & ~full;
    assign req1_rdy = any_val &  grant & memreq_rdy & ~full;

    assign push     = memreq_val & memreq_rdy;
    assign pop      = memresp_val & ~empty;
    assign head_tag = tag_q[head_ptr];

    assign resp0_msg = memresp_msg;
    assign resp1_msg = memresp_msg;
    assign resp0_val = pop & ~head_tag;
    assign resp1_val = pop &  head_tag;

    assign err = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                tail_ptr   <= tail_ptr + 1'b1;
                last_grant <= grant;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (memresp_val && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: tag storage is deliberately not reset; count and pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail_ptr] <= grant;
        end
    end

`ifdef RISCV_MEM_ARB_STATS_EN
    logic [31:0] num_grant0;
    logic [31:0] num_grant1;
    logic [31:0] num_conflict;
    logic [31:0] num_full_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            num_grant0     <= '0;
            num_grant1     <= '0;
            num_conflict   <= '0;
            num_full_stall <= '0;
        end else begin
            if (push && !grant) begin
                num_grant0 <= num_grant0 + 32'd1;
            end
            if (push && grant) begin
                num_grant1 <= num_grant1 + 32'd1;
            end
            if (both_val) begin
                num_conflict <= num_conflict + 32'd1;
            end
            if (any_val && full) begin
                num_full_stall <= num_full_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed vector table, hand sequences and a queue-based random model.
module tb_riscv_mem_arbiter;

    localparam int REQ_W  = 67;
    localparam int RESP_W = 35;
    localparam int MAX    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [REQ_W-1:0]  req0_msg, req1_msg, memreq_msg;
    logic              req0_val, req1_val, req0_rdy, req1_rdy;
    logic [RESP_W-1:0] resp0_msg, resp1_msg, memresp_msg;
    logic              resp0_val, resp1_val;
    logic              memreq_val, memreq_rdy, memresp_val;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(
        .p_req_sz (REQ_W),
        .p_resp_sz(RESP_W),
        .p_max_out(MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_msg   (req0_msg),
        .req0_val   (req0_val),
        .req0_rdy   (req0_rdy),
        .req1_msg   (req1_msg),
        .req1_val   (req1_val),
        .req1_rdy   (req1_rdy),
        .resp0_msg  (resp0_msg),
        .resp0_val  (resp0_val),
        .resp1_msg  (resp1_msg),
        .resp1_val  (resp1_val),
        .memreq_msg (memreq_msg),
        .memreq_val (memreq_val),
        .memreq_rdy (memreq_rdy),
        .memresp_msg(memresp_msg),
        .memresp_val(memresp_val),
        .err        (err)
    );

    typedef struct {
        bit rst, v0, v1, rdy, rv;
        bit mv, r0, r1, sel, o0, o1, er;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: the outstanding-tag queue, last granted port and sticky error.
    bit m_q[$];
    bit m_last;
    bit m_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit v0, input bit v1, input bit rdy, input bit rv,
                         input logic [REQ_W-1:0] m0, input logic [REQ_W-1:0] m1,
                         input logic [RESP_W-1:0] rm);
        @(posedge clk);
        #1;
        reset       = rst;
        req0_val    = v0;
        req1_val    = v1;
        memreq_rdy  = rdy;
        memresp_val = rv;
        req0_msg    = m0;
        req1_msg    = m1;
        memresp_msg = rm;
    endtask

    function automatic vec_t mk(input bit rst, input bit v0, input bit v1, input bit rdy, input bit rv,
                                input bit mv, input bit r0, input bit r1, input bit sel,
                                input bit o0, input bit o1, input bit er);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.v1 = v1; v.rdy = rdy; v.rv = rv;
        v.mv = mv; v.r0 = r0; v.r1 = r1; v.sel = sel; v.o0 = o0; v.o1 = o1; v.er = er;
        return v;
    endfunction

    function automatic logic [REQ_W-1:0] rand_req();
        return REQ_W'({$urandom, $urandom, $urandom});
    endfunction

    // One random cycle: expectations come from the arbitration rules applied to the tag queue.
    task automatic model_cycle(input bit rst, input bit v0, input bit v1, input bit rdy, input bit rv);
        logic [REQ_W-1:0]  m0, m1;
        logic [RESP_W-1:0] rm;
        bit full, g, mv, o0, o1;
        m0 = rand_req();
        m1 = rand_req();
        rm = RESP_W'({$urandom, $urandom});
        drive(rst, v0, v1, rdy, rv, m0, m1, rm);
        @(negedge clk);
        full = (m_q.size() == MAX);
        g    = (v0 && v1) ? !m_last : v1;
        mv   = (v0 || v1) && !full;
        o0   = rv && (m_q.size() > 0) && (m_q[0] == 1'b0);
        o1   = rv && (m_q.size() > 0) && (m_q[0] == 1'b1);
        check("rnd memreq_val", memreq_val, mv);
        check("rnd memreq_msg", memreq_msg, g ? m1 : m0);
        check("rnd req0_rdy", req0_rdy, mv && rdy && !g);
        check("rnd req1_rdy", req1_rdy, mv && rdy && g);
        check("rnd resp0_val", resp0_val, o0);
        check("rnd resp1_val", resp1_val, o1);
        check("rnd resp0_msg", resp0_msg, rm);
        check("rnd resp1_msg", resp1_msg, rm);
        check("rnd err", err, m_err);
        if (!rst) begin
            m_q.delete();
            m_last = 1'b1;
            m_err  = 1'b0;
        end else begin
            if (rv) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (mv && rdy) begin
                m_q.push_back(g);
                m_last = g;
            end
        end
    endtask

    initial begin
        logic [REQ_W-1:0]  c_m0, c_m1;
        logic [RESP_W-1:0] c_rm;
        logic [REQ_W-1:0]  exp_msg;
        int n_resp0, n_resp1;

        c_m0 = 67'h1_2345_6789_ABCD_EF01;
        c_m1 = 67'h6_FEDC_BA98_7654_3210;
        c_rm = 35'h5_A5A5_A5A5;

        reset = 1'b0; req0_val = 1'b0; req1_val = 1'b0; memreq_rdy = 1'b0; memresp_val = 1'b0;
        req0_msg = '0; req1_msg = '0; memresp_msg = '0;

        // Reset state
        drive(0, 0, 0, 0, 0, c_m0, c_m1, c_rm);
        drive(0, 0, 0, 0, 0, c_m0, c_m1, c_rm);
        drive(1, 0, 0, 0, 0, c_m0, c_m1, c_rm);
        @(negedge clk);
        check("reset memreq_val", memreq_val, 1'b0);
        check("reset resp0_val", resp0_val, 1'b0);
        check("reset resp1_val", resp1_val, 1'b0);
        check("reset err", err, 1'b0);
        check("reset count", dut.count, 0);

        // Port 0 only: three requests, each answered one cycle later
        n_resp0 = 0;
        n_resp1 = 0;
        for (int i = 0; i < 4; i++) begin
            exp_msg = {3'd0, 32'(i * 4), 32'h0};
            drive(1, i < 3, 0, 1, i > 0, exp_msg, c_m1, c_rm);
            @(negedge clk);
            if (i < 3) begin
                check($sformatf("p0only memreq_msg %0d", i), memreq_msg, exp_msg);
                check($sformatf("p0only req0_rdy %0d", i), req0_rdy, 1'b1);
            end
            if (resp0_val === 1'b1) n_resp0++;
            if (resp1_val === 1'b1) n_resp1++;
        end
        drive(1, 0, 0, 1, 0, c_m0, c_m1, c_rm);
        @(negedge clk);
        check("p0only resp0 pulses", n_resp0, 3);
        check("p0only resp1 pulses", n_resp1, 0);
        check("p0only count", dut.count, 0);
        check("p0only err", err, 1'b0);

        // Directed table from a fresh reset: alternation, stall hold, full, underflow error, reset mid-flight
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,1,0, 1,1,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,1,1, 1,0,1,1,1,0,0));
        vecs.push_back(mk(1,1,1,1,1, 1,1,0,0,0,1,0));
        vecs.push_back(mk(1,1,1,1,1, 1,0,1,1,1,0,0));
        vecs.push_back(mk(1,1,1,0,1, 1,0,0,0,0,1,0));
        vecs.push_back(mk(1,1,1,0,0, 1,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,0,0, 1,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,1,0, 1,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,1,0, 1,0,1,1,0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 1,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,1,0, 1,0,1,1,0,0,0));
        vecs.push_back(mk(1,1,1,1,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,1,1, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,1,1,1,0, 1,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,1, 0,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,1,1, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,1,1, 0,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,1,1, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,1,1, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,0, 1,0,0,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,1,0, 1,0,1,1,0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 1,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,1,1,0, 1,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,1, 0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,1, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,1));

        drive(0, 0, 0, 0, 0, c_m0, c_m1, c_rm);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v0, vecs[i].v1, vecs[i].rdy, vecs[i].rv, c_m0, c_m1, c_rm);
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("row%0d memreq_val", i), memreq_val, vecs[i].mv);
                check($sformatf("row%0d req0_rdy", i), req0_rdy, vecs[i].r0);
                check($sformatf("row%0d req1_rdy", i), req1_rdy, vecs[i].r1);
                check($sformatf("row%0d memreq_msg", i), memreq_msg, vecs[i].sel ? c_m1 : c_m0);
                check($sformatf("row%0d resp0_val", i), resp0_val, vecs[i].o0);
                check($sformatf("row%0d resp1_val", i), resp1_val, vecs[i].o1);
                check($sformatf("row%0d err", i), err, vecs[i].er);
            end
        end

        // Randomized traffic against the queue model, starting from a reset
        drive(0, 0, 0, 0, 0, c_m0, c_m1, c_rm);
        m_q.delete();
        m_last = 1'b1;
        m_err  = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bit rst, v0, v1, rdy, rv;
            rst = ($urandom_range(0, 49) != 0);
            v0  = ($urandom_range(0, 9) < 7);
            v1  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
            model_cycle(rst, v0, v1, rdy, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-to-one memory request arbiter that lets the instruction port (port 0) and data port (port 1) of `riscv_Core` share one single-ported test memory. It sits between the core and the memory model in the simulation harness. It arbitrates requests round-robin and records the source of every accepted request in an in-order tag FIFO. Each in-order memory response is routed back to the port that issued it.

## Interface

Parameters:
- `p_req_sz`, 67, request message width (type/addr/len/data), passed through unmodified
- `p_resp_sz`, 35, response message width, passed through unmodified
- `p_max_out`, 4, maximum outstanding requests; tag FIFO depth, power of two ≥ 2

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-low
- `req0_msg` / `req1_msg`  in  `p_req_sz`  port 0 (imem) / port 1 (dmem) request message
- `req0_val` / `req1_val`  in  1  request valid
- `req0_rdy` / `req1_rdy`  out  1  request accepted this cycle when val&rdy
- `resp0_msg` / `resp1_msg`  out  `p_resp_sz`  response message, both driven from `memresp_msg`
- `resp0_val` / `resp1_val`  out  1  response valid; consumer always ready
- `memreq_msg`  out  `p_req_sz`  request to memory
- `memreq_val`  out  1  request valid to memory
- `memreq_rdy`  in  1  memory ready
- `memresp_msg`  in  `p_resp_sz`  response from memory; memory returns responses in request order
- `memresp_val`  in  1  response valid; no back-pressure
- `err`  out  1  sticky: response received with no outstanding request

## Operation

- State:
  - `last_grant` (1 bit)
  - tag FIFO of `p_max_out` 1-bit entries, with head/tail pointers and a `count` of `log2(p_max_out)+1` bits
  - `err` flag
- Grant selection (combinational):
  - If only one port is valid, that port is granted.
  - If both are valid, the port ≠ `last_grant` is granted.
  - If neither is valid, no grant.
- `full` = (`count` == `p_max_out`). It is based on registered count only; a same-cycle pop does not free a slot.
- Request outputs:
  - `memreq_val` = (req0_val | req1_val) & !full.
  - `memreq_msg` = message of the granted port; port 0's message when no grant.
- `reqN_rdy` = grantN & memreq_rdy & !full. It is never asserted for the ungranted port.
- Accepted transfer (`memreq_val & memreq_rdy`):
  - Push granted port ID at tail.
  - `last_grant` ← granted port.
- `last_grant` is unchanged on cycles with no transfer, so a stalled grant is held, not re-arbitrated away.
- Response routing:
  - On `memresp_val` with `count` > 0, pop the head.
  - `resp0_val` = memresp_val & head==0; `resp1_val` = memresp_val & head==1.
- Response with `count` == 0:
  - Both `respN_val` = 0, and the response is dropped.
  - `err` ← 1 and stays set until reset.
- Simultaneous push and pop: `count` unchanged and both pointers advance. This is legal at any `count` < `p_max_out`.
- Pointers wrap modulo `p_max_out`.

## Timing

- Reset values (reset low at posedge):
  - `count` = 0, pointers = 0, `last_grant` = 1 (port 0 wins first conflict), `err` = 0.
  - Resulting outputs: `memreq_val` = 0 only if no input is valid; `resp*_val` = 0.
- Request path is combinational, zero added latency.
  - `memreq_val` does not depend on `memreq_rdy`.
  - `reqN_rdy` depends on `memreq_rdy` combinationally.
- Response path is combinational, zero added latency. The FIFO pop takes effect at the same posedge.
- Back-to-back throughput is one request per cycle while not full. Alternating grants under continuous conflict give 50/50 sharing.
- Reset mid-operation clears the FIFO and abandons in-flight tags. The harness resets the memory on or before the same edge; a stale response after reset sets `err`.

## Configuration

- `RISCV_MEM_ARB_STATS_EN` defined: adds internal 32-bit counters, read hierarchically by the harness and cleared by reset.
  - `num_grant0`, `num_grant1`: accepted transfers per port.
  - `num_conflict`: cycles with both valid.
  - `num_full_stall`: cycles with any valid & full.
- Not defined: counters are absent. Port list and functional behaviour are identical in both cases.

## Test plan

- Port 0 only, 3 requests to 0x000, 0x004, 0x008, memreq_rdy=1, responses one cycle later → memreq_msg matches each cycle; resp0_val pulses 3×, resp1_val never; count returns to 0.
- Both valid every cycle for 6 cycles after reset, memory always ready and responding → grants 0,1,0,1,0,1; responses route 0,1,0,1,0,1.
- Both valid, memreq_rdy=0 for 3 cycles then 1 → grant stays on port 0 throughout the stall; req1_rdy=0; after the transfer the next grant is port 1.
- `p_max_out`=4, 4 requests accepted, responses withheld → memreq_val=0 and both rdy=0 while full. Then a response with a same-cycle request → memreq_val still 0 that cycle; it is accepted on the next cycle.
- memresp_val asserted with count=0 → resp0_val=resp1_val=0, err=1 and held. Reset low → err=0.
- Reset asserted with 2 outstanding requests → count=0 next cycle; next conflict is granted to port 0.
